alu_rs: RTL and testbench

ALU reservation station for the Tomasulo out-of-order core. It accepts dispatched ALU operations along with the register file's read ports (data plus producer tag for each operand). It captures missing operands by snooping the CDB and issues ready operations to the ALU through a registered valid/ready stage. Each entry index defines the rename tag that the dispatcher writes into the register file, so the block is the consumer of register-file read data and the source of register-file tags.

---
 rtl/alu_rs.sv | 138 +++++++++++++
 tb/tb_alu_rs.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops, wakes operands from the CDB,
// and issues the lowest-index ready entry through a registered valid/ready stage.
module alu_rs #(
  parameter int unsigned ENTRIES  = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned OP_W     = 6,
  parameter int unsigned TAG_FREE = 0,
  parameter int unsigned TAG_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispValid,
  input  logic [OP_W-1:0]   dispOp,
  input  logic [DATA_W-1:0] dispDataO,
  input  logic [TAG_W-1:0]  dispTagO,
  input  logic [DATA_W-1:0] dispDataT,
  input  logic [TAG_W-1:0]  dispTagT,
  output logic              full,
  output logic [TAG_W-1:0]  allocTag,
  input  logic              enCDB,
  input  logic [TAG_W-1:0]  cdbTag,
  input  logic [DATA_W-1:0] cdbData,
  output logic              issueValid,
  output logic [OP_W-1:0]   issueOp,
  output logic [DATA_W-1:0] issueA,
  output logic [DATA_W-1:0] issueB,
  output logic [TAG_W-1:0]  issueTag,
  input  logic              aluReady
);

  localparam int unsigned      IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [TAG_W-1:0] TFREE = TAG_W'(TAG_FREE);
  localparam logic [TAG_W-1:0] TBASE = TAG_W'(TAG_BASE);

  logic [ENTRIES-1:0] valid;
  logic [OP_W-1:0]    op_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_o  [ENTRIES];
  logic [DATA_W-1:0]  data_o [ENTRIES];
  logic [TAG_W-1:0]   tag_t  [ENTRIES];
  logic [DATA_W-1:0]  data_t [ENTRIES];

  logic [ENTRIES-1:0] ready;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               any_ready;
  logic               advance;
  logic               accept;

  logic [TAG_W-1:0]   d_tag_o;
  logic [DATA_W-1:0]  d_data_o;
  logic [TAG_W-1:0]   d_tag_t;
  logic [DATA_W-1:0]  d_data_t;

  // Priority encoders: lowest free slot for dispatch, lowest ready slot for issue.
  always_comb begin
    ready     = '0;
    free_idx  = '0;
    sel_idx   = '0;
    any_ready = 1'b0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      ready[i] = valid[i] && (tag_o[i] == TFREE) && (tag_t[i] == TFREE);
    end
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
      if (ready[i]) begin
        sel_idx   = IDX_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign full     = &valid;
  assign allocTag = full ? TFREE : TBASE + TAG_W'(free_idx);
  assign advance  = !issueValid || aluReady;
  assign accept   = dispValid && !full;

  // Same-cycle CDB bypass for operands arriving with a pending tag.
  always_comb begin
    d_tag_o  = dispTagO;
    d_data_o = dispDataO;
    d_tag_t  = dispTagT;
    d_data_t = dispDataT;
    if (dispTagO != TFREE && enCDB && cdbTag == dispTagO) begin
      d_tag_o  = TFREE;
      d_data_o = cdbData;
    end
    if (dispTagT != TFREE && enCDB && cdbTag == dispTagT) begin
      d_tag_t  = TFREE;
      d_data_t = cdbData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      issueValid <= 1'b0;
      issueOp    <= '0;
      issueA     <= '0;
      issueB     <= '0;
      issueTag   <= TFREE;
    end else begin
      // CDB snoop on resident entries; both operands may wake together.
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (valid[i] && enCDB && tag_o[i] != TFREE && tag_o[i] == cdbTag) begin
          tag_o[i]  <= TFREE;
          data_o[i] <= cdbData;
        end
        if (valid[i] && enCDB && tag_t[i] != TFREE && tag_t[i] == cdbTag) begin
          tag_t[i]  <= TFREE;
          data_t[i] <= cdbData;
        end
      end

      if (advance) begin
        issueValid <= any_ready;
        if (any_ready) begin
          issueOp        <= op_q[sel_idx];
          issueA         <= data_o[sel_idx];
          issueB         <= data_t[sel_idx];
          issueTag       <= TBASE + TAG_W'(sel_idx);
          valid[sel_idx] <= 1'b0;
        end
      end

      // free_idx is never the issuing entry, so these writes cannot collide.
      if (accept) begin
        valid[free_idx]  <= 1'b1;
        op_q[free_idx]   <= dispOp;
        tag_o[free_idx]  <= d_tag_o;
        data_o[free_idx] <= d_data_o;
        tag_t[free_idx]  <= d_tag_t;
        data_t[free_idx] <= d_data_t;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed table-driven bench for alu_rs: one record per cycle holds the inputs
// for that cycle and the outputs expected before its rising edge.
module tb_alu_rs;

  logic        clk;
  logic        rst;
  logic        dispValid;
  logic [5:0]  dispOp;
  logic [31:0] dispDataO;
  logic [3:0]  dispTagO;
  logic [31:0] dispDataT;
  logic [3:0]  dispTagT;
  logic        full;
  logic [3:0]  allocTag;
  logic        enCDB;
  logic [3:0]  cdbTag;
  logic [31:0] cdbData;
  logic        issueValid;
  logic [5:0]  issueOp;
  logic [31:0] issueA;
  logic [31:0] issueB;
  logic [3:0]  issueTag;
  logic        aluReady;

  alu_rs dut (
    .clk(clk), .rst(rst),
    .dispValid(dispValid), .dispOp(dispOp),
    .dispDataO(dispDataO), .dispTagO(dispTagO),
    .dispDataT(dispDataT), .dispTagT(dispTagT),
    .full(full), .allocTag(allocTag),
    .enCDB(enCDB), .cdbTag(cdbTag), .cdbData(cdbData),
    .issueValid(issueValid), .issueOp(issueOp), .issueA(issueA),
    .issueB(issueB), .issueTag(issueTag), .aluReady(aluReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        dv;
    logic [5:0]  op;
    logic [31:0] d_o;
    logic [3:0]  t_o;
    logic [31:0] d_t;
    logic [3:0]  t_t;
    logic        en;
    logic [3:0]  ctag;
    logic [31:0] cdata;
    logic        rdy;
    logic        e_full;
    logic [3:0]  e_alloc;
    logic        e_iv;
    logic        chk_pl;
    logic [5:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [3:0]  e_tag;
  } vec_t;

  int   nvec = 0;
  int   nmis = 0;
  vec_t tbl[$];

  function automatic vec_t nop(input int f, input int at, input int iv);
    vec_t v;
    v = '{rst: 1'b0, dv: 1'b0, op: '0, d_o: '0, t_o: '0, d_t: '0, t_t: '0,
          en: 1'b0, ctag: '0, cdata: '0, rdy: 1'b1,
          e_full: 1'(f), e_alloc: 4'(at), e_iv: 1'(iv),
          chk_pl: 1'b0, e_op: '0, e_a: '0, e_b: '0, e_tag: '0};
    return v;
  endfunction

  function automatic vec_t disp(input int op, input int d_o, input int t_o,
                                input int d_t, input int t_t,
                                input int f, input int at, input int iv);
    vec_t v;
    v     = nop(f, at, iv);
    v.dv  = 1'b1;
    v.op  = 6'(op);
    v.d_o = 32'(d_o);
    v.t_o = 4'(t_o);
    v.d_t = 32'(d_t);
    v.t_t = 4'(t_t);
    return v;
  endfunction

  function automatic vec_t cdb(input vec_t vi, input int tag, input int data);
    vec_t v;
    v       = vi;
    v.en    = 1'b1;
    v.ctag  = 4'(tag);
    v.cdata = 32'(data);
    return v;
  endfunction

  function automatic vec_t pl(input vec_t vi, input int op, input int a,
                              input int b, input int tag);
    vec_t v;
    v        = vi;
    v.chk_pl = 1'b1;
    v.e_op   = 6'(op);
    v.e_a    = 32'(a);
    v.e_b    = 32'(b);
    v.e_tag  = 4'(tag);
    return v;
  endfunction

  function automatic vec_t rd0(input vec_t vi);
    vec_t v;
    v     = vi;
    v.rdy = 1'b0;
    return v;
  endfunction

  function automatic vec_t rst1(input vec_t vi);
    vec_t v;
    v     = vi;
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] exp);
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", nm, fld, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check before the edge, then advance past it.
  task automatic cyc(input vec_t v, input string nm);
    rst       = v.rst;
    dispValid = v.dv;
    dispOp    = v.op;
    dispDataO = v.d_o;
    dispTagO  = v.t_o;
    dispDataT = v.d_t;
    dispTagT  = v.t_t;
    enCDB     = v.en;
    cdbTag    = v.ctag;
    cdbData   = v.cdata;
    aluReady  = v.rdy;
    @(negedge clk);
    nvec++;
    cmp(nm, "full", 32'(full), 32'(v.e_full));
    cmp(nm, "allocTag", 32'(allocTag), 32'(v.e_alloc));
    cmp(nm, "issueValid", 32'(issueValid), 32'(v.e_iv));
    if (v.chk_pl) begin
      cmp(nm, "issueOp", 32'(issueOp), 32'(v.e_op));
      cmp(nm, "issueA", issueA, v.e_a);
      cmp(nm, "issueB", issueB, v.e_b);
      cmp(nm, "issueTag", 32'(issueTag), 32'(v.e_tag));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and a simple two-operand-ready op.
    tbl.push_back(pl(nop(0, 1, 0), 0, 0, 0, 0));
    tbl.push_back(disp(3, 5, 0, 7, 0, 0, 1, 0));
    tbl.push_back(nop(0, 2, 0));
    tbl.push_back(pl(nop(0, 1, 1), 3, 5, 7, 1));
    tbl.push_back(nop(0, 1, 0));
    // Operand 1 waits on tag 9, woken three cycles after dispatch.
    tbl.push_back(disp(4, 0, 9, 'h22, 0, 0, 1, 0));
    tbl.push_back(nop(0, 2, 0));
    tbl.push_back(nop(0, 2, 0));
    tbl.push_back(cdb(nop(0, 2, 0), 9, 'hABCD));
    tbl.push_back(nop(0, 2, 0));
    tbl.push_back(pl(nop(0, 1, 1), 4, 'hABCD, 'h22, 1));
    tbl.push_back(nop(0, 1, 0));
    // Dispatch-time bypass of operand 2.
    tbl.push_back(cdb(disp(5, 'h33, 0, 0, 9, 0, 1, 0), 9, 'h11));
    tbl.push_back(nop(0, 2, 0));
    tbl.push_back(pl(nop(0, 1, 1), 5, 'h33, 'h11, 1));
    tbl.push_back(nop(0, 1, 0));
    // Fill all entries waiting on tag 12, reject a ninth, then drain in index order.
    for (int k = 0; k < 8; k++) tbl.push_back(disp(k, 0, 12, 'h100 + k, 0, 0, 1 + k, 0));
    tbl.push_back(disp('h3F, 1, 0, 2, 0, 1, 0, 0));
    tbl.push_back(cdb(nop(1, 0, 0), 12, 'hC0DE));
    tbl.push_back(nop(1, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(pl(nop(0, 1, 1), k, 'hC0DE, 'h100 + k, k + 1));
    tbl.push_back(nop(0, 1, 0));
    // Both operands of one entry woken by a single broadcast.
    tbl.push_back(disp(6, 0, 13, 0, 13, 0, 1, 0));
    tbl.push_back(nop(0, 2, 0));
    tbl.push_back(cdb(nop(0, 2, 0), 13, 'h77));
    tbl.push_back(nop(0, 2, 0));
    tbl.push_back(pl(nop(0, 1, 1), 6, 'h77, 'h77, 1));
    tbl.push_back(nop(0, 1, 0));

    rst = 1'b1; dispValid = 1'b0; dispOp = '0; dispDataO = '0; dispTagO = '0;
    dispDataT = '0; dispTagT = '0; enCDB = 1'b0; cdbTag = '0; cdbData = '0;
    aluReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], $sformatf("vec%0d", i));

    // Stalled ALU: issue register holds, second ready entry follows release.
    cyc(rd0(disp('hA, 1, 0, 2, 0, 0, 1, 0)), "stall_d1");
    cyc(rd0(disp('hB, 3, 0, 4, 0, 0, 2, 0)), "stall_d2");
    for (int k = 0; k < 5; k++) cyc(rd0(pl(nop(0, 1, 1), 'hA, 1, 2, 1)), $sformatf("stall_hold%0d", k));
    cyc(pl(nop(0, 1, 1), 'hA, 1, 2, 1), "stall_release");
    cyc(pl(nop(0, 1, 1), 'hB, 3, 4, 2), "stall_second");
    cyc(nop(0, 1, 0), "stall_empty");

    // Mid-operation reset with three resident entries and a held issue.
    cyc(rd0(disp('h1, 'h10, 0, 'h20, 0, 0, 1, 0)), "rst_d0");
    cyc(rd0(disp('h2, 0, 14, 0, 0, 0, 2, 0)), "rst_d1");
    cyc(rd0(pl(disp('h3, 0, 14, 0, 0, 0, 1, 1), 'h1, 'h10, 'h20, 1)), "rst_d2");
    cyc(rd0(pl(disp('h4, 0, 14, 0, 0, 0, 3, 1), 'h1, 'h10, 'h20, 1)), "rst_d3");
    cyc(rst1(cdb(pl(disp('h5, 1, 0, 1, 0, 0, 4, 1), 'h1, 'h10, 'h20, 1), 14, 'h99)), "rst_pulse");
    cyc(cdb(pl(nop(0, 1, 0), 0, 0, 0, 0), 14, 'h99), "rst_after");
    for (int k = 0; k < 4; k++) cyc(nop(0, 1, 0), $sformatf("rst_quiet%0d", k));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
